// File: rtl/plb_access_arbiter_pkg.sv
// Shared types for the PLB access arbiter: flush FSM states and requester IDs.
package mpt_pkg;
  typedef enum logic [1:0] {ARB = 2'd0, DRAIN = 2'd1, INV = 2'd2, WAIT = 2'd3} plb_arb_state_e;
  typedef enum logic {PLB_ARB_LKP = 1'b0, PLB_ARB_FILL = 1'b1} plb_arb_id_e;
endpackage

// File: rtl/plb_access_arbiter_if.sv
// MEM bundle: req/gnt handshake, one in-order valid per grant.
interface plb_access_arbiter_if #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 64
);
  logic                    req, gnt, valid, we, error;
  logic [ADDR_WIDTH-1:0]   addr;
  logic [DATA_WIDTH-1:0]   rdata, wdata;
  logic [DATA_WIDTH/8-1:0] be;

  modport master (output req, addr, wdata, we, be, input gnt, valid, rdata, error);
  modport slave  (input req, addr, wdata, we, be, output gnt, valid, rdata, error);
endinterface

// File: rtl/plb_access_arbiter_id_fifo.sv
// Requester-ID FIFO: one bit per granted-but-unanswered PLB request.
module plb_arb_id_fifo #(
  parameter int DEPTH = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic push,
  input  logic pop,
  input  logic din,
  output logic dout,
  output logic full,
  output logic empty
);
  localparam int AW = $clog2(DEPTH);

  logic [DEPTH-1:0] mem_q;
  logic [AW:0]      wr_q, rd_q;
  logic             push_ok, pop_ok;

  assign empty   = (wr_q == rd_q);
  assign full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign dout    = mem_q[rd_q[AW-1:0]];
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mem_q <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
    end else begin
      if (push_ok) begin
        mem_q[wr_q[AW-1:0]] <= din;
        wr_q <= wr_q + 1'b1;
      end
      if (pop_ok) rd_q <= rd_q + 1'b1;
    end
  end
endmodule

// File: rtl/plb_access_arbiter.sv
// Round-robin sharing of the PLB port between lookup and refill, plus flush/invalidate sequencing.
// Define PLB_ARB_PERF_CNT_EN to build the grant/conflict performance counters.
module plb_access_arbiter
  import mpt_pkg::*;
#(
  parameter int                    DATA_WIDTH      = 64,
  parameter int                    ADDR_WIDTH      = 64,
  parameter int                    MAX_OUTSTANDING = 4,
  parameter logic [ADDR_WIDTH-1:0] FLUSH_CMD_ADDR  = '1,
  parameter int                    CNT_WIDTH       = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  plb_access_arbiter_if.slave  lkp_slave_mem,
  plb_access_arbiter_if.slave  fill_slave_mem,
  plb_access_arbiter_if.master plb_master_mem,
  input  logic                 flush_i,
  output logic                 flush_busy_o,
  output logic                 flush_done_o,
  output logic                 proto_err_o,
  output logic [CNT_WIDTH-1:0] lkp_grants_o,
  output logic [CNT_WIDTH-1:0] fill_grants_o,
  output logic [CNT_WIDTH-1:0] conflict_cyc_o
);
  localparam logic [1:0] S_ARB   = ARB;
  localparam logic [1:0] S_DRAIN = DRAIN;
  localparam logic [1:0] S_INV   = INV;
  localparam logic [1:0] S_WAIT  = WAIT;

  logic [1:0]              state_q, state_d;
  plb_arb_id_e             sel, lock_id_q, rr_q, head_id;
  logic                    locked_q, flush_pend_q, proto_err_q;
  logic                    slv_req, flush_req, fwd, mst_gnt, resp;
  logic                    fifo_full, fifo_empty, fifo_head;
  logic [DATA_WIDTH-1:0]   cmd_wdata;
  logic [DATA_WIDTH/8-1:0] cmd_be;

  assign cmd_wdata = '0;
  assign cmd_be    = '1;

  // A held (ungranted) request keeps its owner; otherwise round-robin among requesters.
  always_comb begin
    if (locked_q)                                sel = lock_id_q;
    else if (lkp_slave_mem.req && fill_slave_mem.req) sel = rr_q;
    else if (lkp_slave_mem.req)                  sel = PLB_ARB_LKP;
    else                                         sel = PLB_ARB_FILL;
  end

  assign slv_req   = (sel == PLB_ARB_FILL) ? fill_slave_mem.req : lkp_slave_mem.req;
  assign flush_req = (state_q == S_ARB) && (flush_i || flush_pend_q);
  assign fwd       = (state_q == S_ARB) && !fifo_full && slv_req && (locked_q || !flush_req);
  assign mst_gnt   = fwd && plb_master_mem.gnt;

  always_comb begin
    plb_master_mem.req   = fwd;
    plb_master_mem.addr  = (sel == PLB_ARB_FILL) ? fill_slave_mem.addr  : lkp_slave_mem.addr;
    plb_master_mem.wdata = (sel == PLB_ARB_FILL) ? fill_slave_mem.wdata : lkp_slave_mem.wdata;
    plb_master_mem.we    = (sel == PLB_ARB_FILL) ? fill_slave_mem.we    : lkp_slave_mem.we;
    plb_master_mem.be    = (sel == PLB_ARB_FILL) ? fill_slave_mem.be    : lkp_slave_mem.be;
    if (state_q == S_INV) begin
      plb_master_mem.req   = 1'b1;
      plb_master_mem.we    = 1'b1;
      plb_master_mem.addr  = FLUSH_CMD_ADDR;
      plb_master_mem.wdata = cmd_wdata;
      plb_master_mem.be    = cmd_be;
    end
  end

  assign lkp_slave_mem.gnt  = mst_gnt && (sel == PLB_ARB_LKP);
  assign fill_slave_mem.gnt = mst_gnt && (sel == PLB_ARB_FILL);

  // The invalidate command is never pushed, so its response always finds the FIFO empty.
  assign head_id              = plb_arb_id_e'(fifo_head);
  assign resp                 = plb_master_mem.valid && !fifo_empty;
  assign lkp_slave_mem.valid  = resp && (head_id == PLB_ARB_LKP);
  assign fill_slave_mem.valid = resp && (head_id == PLB_ARB_FILL);
  assign lkp_slave_mem.error  = lkp_slave_mem.valid && plb_master_mem.error;
  assign fill_slave_mem.error = fill_slave_mem.valid && plb_master_mem.error;
  assign lkp_slave_mem.rdata  = plb_master_mem.rdata;
  assign fill_slave_mem.rdata = plb_master_mem.rdata;

  plb_arb_id_fifo #(.DEPTH(MAX_OUTSTANDING)) u_id_fifo (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .push  (mst_gnt),
    .pop   (resp),
    .din   (sel),
    .dout  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_ARB:   if (flush_req && (!locked_q || plb_master_mem.gnt)) state_d = S_DRAIN;
      S_DRAIN: if (fifo_empty)           state_d = S_INV;
      S_INV:   if (plb_master_mem.gnt)   state_d = S_WAIT;
      default: if (plb_master_mem.valid) state_d = S_ARB;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= S_ARB;
      locked_q     <= 1'b0;
      lock_id_q    <= PLB_ARB_LKP;
      rr_q         <= PLB_ARB_LKP;
      flush_pend_q <= 1'b0;
      proto_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      locked_q     <= fwd && !plb_master_mem.gnt;
      if (fwd) lock_id_q <= sel;
      if (mst_gnt) rr_q <= (sel == PLB_ARB_LKP) ? PLB_ARB_FILL : PLB_ARB_LKP;
      flush_pend_q <= flush_req && (state_d == S_ARB);
      if (plb_master_mem.valid && fifo_empty && state_q != S_WAIT) proto_err_q <= 1'b1;
    end
  end

  assign flush_busy_o = (state_q != S_ARB);
  assign flush_done_o = (state_q == S_WAIT) && plb_master_mem.valid;
  assign proto_err_o  = proto_err_q;

`ifdef PLB_ARB_PERF_CNT_EN
  logic [CNT_WIDTH-1:0] lkp_cnt_q, fill_cnt_q, conf_cnt_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      lkp_cnt_q  <= '0;
      fill_cnt_q <= '0;
      conf_cnt_q <= '0;
    end else begin
      if (lkp_slave_mem.gnt)  lkp_cnt_q  <= lkp_cnt_q + CNT_WIDTH'(1);
      if (fill_slave_mem.gnt) fill_cnt_q <= fill_cnt_q + CNT_WIDTH'(1);
      if (lkp_slave_mem.req && fill_slave_mem.req) conf_cnt_q <= conf_cnt_q + CNT_WIDTH'(1);
    end
  end

  assign lkp_grants_o   = lkp_cnt_q;
  assign fill_grants_o  = fill_cnt_q;
  assign conflict_cyc_o = conf_cnt_q;
`else
  assign lkp_grants_o   = '0;
  assign fill_grants_o  = '0;
  assign conflict_cyc_o = '0;
`endif
endmodule
